// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared types and constants for the UART receive controller.
// Holds the FSM state encoding, the legal oversampling ratios and the frame data width.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ERR_CHK
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int         DATA_WIDTH    = 8;
  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample position (edge_cnt) and bit index (bit_cnt)
// within a frame. Both counters sit at zero while enable is low, so the first
// enabled cycle of a frame always starts at edge 0 / bit 0.
module uart_rx_edge_bit_counter
  import uart_rx_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [5:0] Prescale,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       wrap
);

  // Last oversample of the current bit.
  assign wrap = enable && (edge_cnt == Prescale - 6'd1);

  // Advance the oversample position, bumping the bit index at each wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-level controller of an oversampling UART receiver.
// Sequences start/data/parity/stop bits, raises the datapath enables in the
// middle of each bit and reports one-cycle frame results in ERR_CHK.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       sampled_bit,
  input  logic       par_err,
  input  logic       strt_glitch,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error
);

  rx_state_t  state;
  logic [5:0] prescale_q;
  logic [3:0] bit_cnt;
  logic       wrap;
  logic       cnt_en;
  logic [5:0] mid_cnt;
  logic       start_abort;
  logic       stop_exit;
  logic       par_fail;
  logic       unused_inputs;

`ifdef UART_RX_PARITY_EN
  logic par_en_q;

  assign par_fail      = par_en_q && par_err;
  assign unused_inputs = sampled_bit;
`else
  assign par_fail      = 1'b0;
  assign par_chk_en    = 1'b0;
  assign parity_error  = 1'b0;
  assign unused_inputs = &{1'b0, sampled_bit, PAR_EN, par_err};
`endif

  // Sample point of a bit; the sampler's vote is valid here.
  assign mid_cnt = {1'b0, prescale_q[5:1]} + 6'd2;

  // Checker results arrive one cycle after the sample point.
  assign start_abort = (state == START) && (edge_cnt == mid_cnt + 6'd1) && strt_glitch;
  assign stop_exit   = (state == STOP)  && (edge_cnt == mid_cnt + 6'd1);

  // Counting stops on the cycle the frame is left, so edge_cnt reads 0 afterwards.
  assign cnt_en = dat_samp_en && !start_abort && !stop_exit;

  uart_rx_edge_bit_counter u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (cnt_en),
    .Prescale (prescale_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap)
  );

  // Frame FSM with registered enables; strobes are set one cycle early so they
  // line up with edge_cnt == mid_cnt.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      prescale_q    <= PRESCALE_8;
      dat_samp_en   <= 1'b0;
      deser_en      <= 1'b0;
      strt_chk_en   <= 1'b0;
      stp_chk_en    <= 1'b0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q      <= 1'b0;
      par_chk_en    <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle and are re-raised only where needed,
      // which keeps every pulse exactly one cycle wide.
      deser_en      <= 1'b0;
      strt_chk_en   <= 1'b0;
      stp_chk_en    <= 1'b0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk_en    <= 1'b0;
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Frame configuration is captured only while the line is idle.
          prescale_q <= legal_prescale(Prescale);
`ifdef UART_RX_PARITY_EN
          par_en_q   <= PAR_EN;
`endif
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
          end
        end

        START: begin
          if (edge_cnt == mid_cnt - 6'd1) strt_chk_en <= 1'b1;
          if (start_abort) begin
            state       <= IDLE;
            dat_samp_en <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (edge_cnt == mid_cnt - 6'd1) deser_en <= 1'b1;
          if (wrap && (bit_cnt == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
            state <= par_en_q ? PARITY : STOP;
`else
            state <= STOP;
`endif
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (edge_cnt == mid_cnt - 6'd1) par_chk_en <= 1'b1;
          if (wrap) state <= STOP;
        end
`endif

        STOP: begin
          if (edge_cnt == mid_cnt - 6'd1) stp_chk_en <= 1'b1;
          // Leave mid-stop-bit so a back-to-back start bit is not missed.
          if (stop_exit) begin
            state         <= ERR_CHK;
            dat_samp_en   <= 1'b0;
            data_valid    <= !stp_err && !par_fail;
            framing_error <= stp_err;
`ifdef UART_RX_PARITY_EN
            parity_error  <= par_fail;
`endif
          end
        end

        ERR_CHK: begin
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl.
// A clean serial line feeds sampled_bit directly; a small checker model
// produces strt_glitch / par_err / stp_err and reassembles the data byte.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       sampled_bit;
  logic       par_err;
  logic       strt_glitch;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, parity_error, framing_error;

`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  uart_rx_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .sampled_bit   (sampled_bit),
    .par_err       (par_err),
    .strt_glitch   (strt_glitch),
    .stp_err       (stp_err),
    .edge_cnt      (edge_cnt),
    .dat_samp_en   (dat_samp_en),
    .deser_en      (deser_en),
    .strt_chk_en   (strt_chk_en),
    .par_chk_en    (par_chk_en),
    .stp_chk_en    (stp_chk_en),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int t_valid  = 0;

  int n_deser = 0, n_strt = 0, n_par = 0, n_valid = 0, n_perr = 0, n_ferr = 0;
  int n_wide = 0, n_gap1 = 0;
  int b_deser, b_strt, b_par, b_valid, b_perr, b_ferr, b_gap1;

  logic [7:0] shreg;
  logic [7:0] rx_byte = 8'h00;
  logic dv_q = 1'b0, pe_q = 1'b0, fe_q = 1'b0, dse_q1 = 1'b0, dse_q2 = 1'b0;

  assign sampled_bit = RX_IN;

  always @(posedge CLK) cyc <= cyc + 1;

  // Checker model: registered results one cycle after each check enable.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      shreg       <= 8'h00;
    end else begin
      if (strt_chk_en) strt_glitch <= sampled_bit;
      if (deser_en)    shreg       <= {sampled_bit, shreg[7:1]};
      if (par_chk_en)  par_err     <= sampled_bit ^ (^shreg);
      if (stp_chk_en)  stp_err     <= ~sampled_bit;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (deser_en)      n_deser++;
    if (strt_chk_en)   n_strt++;
    if (par_chk_en)    n_par++;
    if (parity_error)  n_perr++;
    if (framing_error) n_ferr++;
    if (data_valid) begin
      n_valid++;
      t_valid = cyc;
      rx_byte = shreg;
    end
    if ((data_valid && dv_q) || (parity_error && pe_q) || (framing_error && fe_q)) n_wide++;
    if (dse_q2 && !dse_q1 && dat_samp_en) n_gap1++;
    dv_q   = data_valid;
    pe_q   = parity_error;
    fe_q   = framing_error;
    dse_q2 = dse_q1;
    dse_q1 = dat_samp_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic snap();
    b_deser = n_deser; b_strt = n_strt; b_par  = n_par;  b_valid = n_valid;
    b_perr  = n_perr;  b_ferr = n_ferr; b_gap1 = n_gap1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_edge"},  32'(edge_cnt), 32'd0);
    check({tag, "_ens"},   32'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 32'd0);
    check({tag, "_flags"}, 32'({data_valid, parity_error, framing_error}), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int e_deser, input int e_par,
                             input int e_valid, input int e_perr, input int e_ferr);
    check({tag, "_deser"}, 32'(n_deser - b_deser), 32'(e_deser));
    check({tag, "_parchk"}, 32'(n_par - b_par), 32'(e_par));
    check({tag, "_valid"}, 32'(n_valid - b_valid), 32'(e_valid));
    check({tag, "_perr"}, 32'(n_perr - b_perr), 32'(e_perr));
    check({tag, "_ferr"}, 32'(n_ferr - b_ferr), 32'(e_ferr));
  endtask

  task automatic send_bit(input logic b, input int len);
    RX_IN = b;
    repeat (len) @(negedge CLK);
  endtask

  // Drives one frame on the line, starting at a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input int p, input bit with_par,
                            input bit par_flip, input logic stop_val, input int stop_len);
    t_start = cyc;
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (with_par) send_bit((^d) ^ par_flip, p);
    send_bit(stop_val, stop_len);
    RX_IN = 1'b1;
  endtask

  initial begin
    #1 RST = 1'b1;
    #1 check_outputs_zero("reset");
    tick(3);
    RST = 1'b0;
    tick(3);

    // Prescale 8, parity enabled, 0xA5 with correct even parity.
    Prescale = 6'd8; PAR_EN = 1'b1;
    snap();
    send_frame(8'hA5, 8, HAS_PAR, 1'b0, 1'b1, 8);
    tick(16);
    check_frame("good_a5", 8, HAS_PAR ? 1 : 0, 1, 0, 0);
    check("good_a5_latency", 32'(t_valid - t_start), HAS_PAR ? 32'd89 : 32'd81);
    check("good_a5_byte", 32'(rx_byte), 32'hA5);
    check("good_a5_idle", 32'(dat_samp_en), 32'd0);

    // Same frame with the parity bit flipped.
    snap();
    send_frame(8'hA5, 8, HAS_PAR, 1'b1, 1'b1, 8);
    tick(16);
    check_frame("bad_par", 8, HAS_PAR ? 1 : 0, HAS_PAR ? 0 : 1, HAS_PAR ? 1 : 0, 0);

    // Start bit that lasts only 3 cycles.
    snap();
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(20);
    check_frame("glitch", 0, 0, 0, 0, 0);
    check("glitch_strtchk", 32'(n_strt - b_strt), 32'd1);
    check("glitch_idle", 32'(dat_samp_en), 32'd0);

    // Prescale 16, no parity, stop bit low.
    Prescale = 6'd16; PAR_EN = 1'b0;
    tick(2);
    snap();
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 16);
    tick(60);
    check_frame("stop_err", 8, 0, 0, 0, 1);

    // Prescale 32, back-to-back 0x00 then 0xFF; second start lands in ERR_CHK.
    Prescale = 6'd32;
    tick(2);
    snap();
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, 32 / 2 + 5);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, 32);
    tick(40);
    check_frame("b2b", 16, 0, 2, 0, 0);
    check("b2b_gap", 32'(n_gap1 - b_gap1), 32'd1);
    check("b2b_byte", 32'(rx_byte), 32'hFF);

    // Reset during the 4th data bit, then a full frame.
    Prescale = 6'd8; PAR_EN = 1'b1;
    tick(2);
    snap();
    send_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 8);
    RX_IN = 1'b1;
    tick(4);
    #2 RST = 1'b1;
    #1 check_outputs_zero("mid_reset");
    tick(2);
    RST = 1'b0;
    tick(10);
    check_frame("aborted", 3, 0, 0, 0, 0);
    snap();
    send_frame(8'h5A, 8, HAS_PAR, 1'b0, 1'b1, 8);
    tick(16);
    check_frame("after_rst", 8, HAS_PAR ? 1 : 0, 1, 0, 0);
    check("after_rst_byte", 32'(rx_byte), 32'h5A);

    // Configuration changes mid-frame do not affect the frame in flight.
    snap();
    fork
      send_frame(8'hC3, 8, HAS_PAR, 1'b0, 1'b1, 8);
      begin
        tick(20);
        PAR_EN   = 1'b0;
        Prescale = 6'd16;
      end
    join
    tick(16);
    check_frame("cfg_hold", 8, HAS_PAR ? 1 : 0, 1, 0, 0);
    check("cfg_hold_byte", 32'(rx_byte), 32'hC3);

    // An illegal ratio behaves as 8.
    Prescale = 6'd12; PAR_EN = 1'b0;
    tick(2);
    snap();
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 8);
    tick(16);
    check_frame("ps_illegal", 8, 0, 1, 0, 0);
    check("ps_illegal_latency", 32'(t_valid - t_start), 32'd81);
    check("ps_illegal_byte", 32'(rx_byte), 32'h81);

    check("pulse_width", 32'(n_wide), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, receive oversampling clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port RX_IN, input, 1, serial line, idle high.
REQ-004 SHALL have port Prescale, input, 6, oversampling ratio; legal values are 8, 16 and 32, and any other value is treated as 8.
REQ-005 SHALL have port PAR_EN, input, 1, parity bit present in frame.
REQ-006 SHALL have port sampled_bit, input, 1, majority-voted bit from the sampler; valid when edge_cnt = Prescale/2+2.
REQ-007 SHALL have ports par_err, strt_glitch and stp_err, each input, 1, registered checker results, valid one cycle after the matching check enable.
REQ-008 SHALL have port edge_cnt, output, 6, oversample position within the current bit.
REQ-009 SHALL have ports dat_samp_en, deser_en, strt_chk_en, par_chk_en and stp_chk_en, each output, 1, datapath enables.
REQ-010 SHALL have ports data_valid, parity_error and framing_error, each output, 1, frame-result pulses.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and ERR_CHK.
REQ-012 edge_cnt SHALL run from 0 to Prescale-1 in every state except IDLE and ERR_CHK, and wrap to 0 at the end of the bit.
REQ-013 bit_cnt (internal, 4 bits) SHALL increment on each wrap, clear on entry to START, and count the data bits 1..8 in DATA.
REQ-014 In IDLE, RX_IN=0 SHALL move the FSM to START on the next cycle with edge_cnt=0.
REQ-015 strt_chk_en SHALL pulse for one cycle at edge_cnt=Prescale/2+2 in START.
REQ-016 START SHALL go to IDLE if strt_glitch=1 on the following cycle, and otherwise to DATA at the wrap.
REQ-017 deser_en SHALL pulse at edge_cnt=Prescale/2+2 for each of the 8 DATA bits (LSB first).
REQ-018 After the 8th data-bit wrap, DATA SHALL go to PARITY if PAR_EN=1, else to STOP.
REQ-019 par_chk_en SHALL pulse at edge_cnt=Prescale/2+2 in PARITY, and PARITY SHALL go to STOP at the wrap.
REQ-020 stp_chk_en SHALL pulse at edge_cnt=Prescale/2+2 in STOP, and STOP SHALL go to ERR_CHK on the next cycle (mid-stop-bit exit).
REQ-021 ERR_CHK SHALL last exactly 1 cycle, with data_valid = !stp_err & !(PAR_EN & par_err), parity_error = PAR_EN & par_err, and framing_error = stp_err.
REQ-022 ERR_CHK SHALL go to START if RX_IN=0 (back-to-back frame), else to IDLE.
REQ-023 dat_samp_en SHALL be high in START, DATA, PARITY and STOP, and low in IDLE and ERR_CHK.
REQ-024 PAR_EN and Prescale SHALL be sampled only in IDLE and held for the frame; changes mid-frame have no effect until the next frame.
REQ-025 All outputs SHALL be registered, and result pulses SHALL be exactly 1 cycle wide.

Reset
REQ-026 RST=1 SHALL force the FSM to IDLE, edge_cnt=0, bit_cnt=0 and all enables and flags to 0, asynchronously.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no data_valid or error pulse, and reception SHALL resume at the next falling edge after release.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, parity behaviour SHALL be as specified above.
REQ-029 Without UART_RX_PARITY_EN, the PARITY state and par_chk_en logic SHALL be absent: PAR_EN and par_err are ignored, DATA goes directly to STOP, and par_chk_en and parity_error are tied to 0.

Structure
REQ-030 A shared package SHALL hold the state enum, the legal prescale constants (8/16/32) and the data width constant 8.
REQ-031 A sub-module uart_rx_edge_bit_counter SHALL hold the edge_cnt/bit_cnt logic, with enable, Prescale and wrap outputs.

Verification
REQ-032 Prescale=8, PAR_EN=1, frame 0xA5 with correct even parity and stop=1 -> 8 deser_en pulses, then data_valid=1 for 1 cycle 89 cycles after the start edge.
REQ-033 Same frame with the parity bit flipped (par_err=1) -> parity_error=1, data_valid=0.
REQ-034 Start low for 3 cycles then high (strt_glitch=1) -> return to IDLE, no deser_en pulses, no flags.
REQ-035 Prescale=16, PAR_EN=0, stop bit=0 (stp_err=1) -> framing_error=1, data_valid=0, no par_chk_en pulse.
REQ-036 Two back-to-back frames 0x00 and 0xFF, Prescale=32 -> ERR_CHK goes straight to START and two data_valid pulses occur.
REQ-037 RST pulsed during DATA bit 4 -> all outputs 0 immediately, and the next full frame is received correctly.
